// File: rtl/cw_pkg.sv
// Shared CW definitions: FSM states, ASCII codes, element encoding and
// timing thresholds expressed in Morse units.
package cw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } cw_state_e;

  localparam logic [6:0] SPACE_CHAR = 7'h20;
  localparam logic [6:0] ERR_CHAR   = 7'h3F;

  localparam logic DIT = 1'b0;
  localparam logic DAH = 1'b1;

  localparam int DAH_MIN  = 2;
  localparam int CHAR_GAP = 2;
  localparam int WORD_GAP = 5;
  localparam int SAT      = 8;

endpackage

// File: rtl/cw_morse_lut.sv
// Combinational Morse-to-ASCII lookup for A-Z and 0-9. The first element
// sits at bit sym_len-1; bits above sym_len are ignored.
module cw_morse_lut
  import cw_pkg::*;
(
  input  logic [2:0] sym_len,
  input  logic [4:0] sym_bits,
  output logic [6:0] ascii,
  output logic       hit
);

  logic [5:0] mask;
  logic [7:0] key;

  always_comb begin
    mask  = (6'd1 << sym_len) - 6'd1;
    key   = {sym_len, sym_bits & mask[4:0]};
    ascii = ERR_CHAR;
    hit   = 1'b1;
    case (key)
      {3'd2, 5'b00001}: ascii = 7'h41;
      {3'd4, 5'b01000}: ascii = 7'h42;
      {3'd4, 5'b01010}: ascii = 7'h43;
      {3'd3, 5'b00100}: ascii = 7'h44;
      {3'd1, 5'b00000}: ascii = 7'h45;
      {3'd4, 5'b00010}: ascii = 7'h46;
      {3'd3, 5'b00110}: ascii = 7'h47;
      {3'd4, 5'b00000}: ascii = 7'h48;
      {3'd2, 5'b00000}: ascii = 7'h49;
      {3'd4, 5'b00111}: ascii = 7'h4A;
      {3'd3, 5'b00101}: ascii = 7'h4B;
      {3'd4, 5'b00100}: ascii = 7'h4C;
      {3'd2, 5'b00011}: ascii = 7'h4D;
      {3'd2, 5'b00010}: ascii = 7'h4E;
      {3'd3, 5'b00111}: ascii = 7'h4F;
      {3'd4, 5'b00110}: ascii = 7'h50;
      {3'd4, 5'b01101}: ascii = 7'h51;
      {3'd3, 5'b00010}: ascii = 7'h52;
      {3'd3, 5'b00000}: ascii = 7'h53;
      {3'd1, 5'b00001}: ascii = 7'h54;
      {3'd3, 5'b00001}: ascii = 7'h55;
      {3'd4, 5'b00001}: ascii = 7'h56;
      {3'd3, 5'b00011}: ascii = 7'h57;
      {3'd4, 5'b01001}: ascii = 7'h58;
      {3'd4, 5'b01011}: ascii = 7'h59;
      {3'd4, 5'b01100}: ascii = 7'h5A;
      {3'd5, 5'b11111}: ascii = 7'h30;
      {3'd5, 5'b01111}: ascii = 7'h31;
      {3'd5, 5'b00111}: ascii = 7'h32;
      {3'd5, 5'b00011}: ascii = 7'h33;
      {3'd5, 5'b00001}: ascii = 7'h34;
      {3'd5, 5'b00000}: ascii = 7'h35;
      {3'd5, 5'b10000}: ascii = 7'h36;
      {3'd5, 5'b11000}: ascii = 7'h37;
      {3'd5, 5'b11100}: ascii = 7'h38;
      {3'd5, 5'b11110}: ascii = 7'h39;
      default: begin
        ascii = ERR_CHAR;
        hit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cw_rx_decoder.sv
// CW receive decoder: synchronise and filter the keyed line, time marks and
// spaces in units, assemble elements and emit one ASCII code per character.
module cw_rx_decoder
  import cw_pkg::*;
#(
  parameter int UNIT_CYCLES   = 12500,
  parameter int FILTER_CYCLES = 64,
  parameter int MAX_ELEMS     = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_in,
  output logic       char_valid,
  output logic [6:0] char_ascii,
  output logic       char_err,
  output logic       busy
);

  localparam int CW = $clog2(SAT * UNIT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  localparam logic [CW-1:0] DAH_T  = CW'(DAH_MIN  * UNIT_CYCLES);
  localparam logic [CW-1:0] CHAR_T = CW'(CHAR_GAP * UNIT_CYCLES);
  localparam logic [CW-1:0] WORD_T = CW'(WORD_GAP * UNIT_CYCLES);
  localparam logic [CW-1:0] SAT_T  = CW'(SAT      * UNIT_CYCLES);
  localparam logic [FW-1:0] F_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [2:0]    LEN_MAX = 3'(MAX_ELEMS);

  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic                 lvl_q, lvl_d;
  logic [FW-1:0]        flt_cnt_q, flt_cnt_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  cw_state_e            state_q, state_d;
  logic [MAX_ELEMS-1:0] sym_bits_q, sym_bits_d;
  logic [2:0]           sym_len_q, sym_len_d;
  logic                 ovf_q, ovf_d, stuck_q, stuck_d, emitted_q, emitted_d;
  logic                 char_valid_q, char_valid_d, char_err_q, char_err_d;
  logic [6:0]           char_ascii_q, char_ascii_d;

  logic       toggle, rise, fall, elem, bad, emit_char;
  logic [6:0] lut_ascii;
  logic       lut_hit;

  cw_morse_lut u_lut (
    .sym_len  (sym_len_q),
    .sym_bits (5'(sym_bits_q)),
    .ascii    (lut_ascii),
    .hit      (lut_hit)
  );

  // The edge is flagged in the cycle the filter decides to toggle, so the
  // FSM and lvl update on the same clock edge.
  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    lvl_d     = lvl_q;
    flt_cnt_d = '0;
    toggle    = 1'b0;
    if (sync2_q != lvl_q) begin
      if (flt_cnt_q == F_LAST) begin
        lvl_d  = sync2_q;
        toggle = 1'b1;
      end else begin
        flt_cnt_d = flt_cnt_q + FW'(1);
      end
    end
    rise  = toggle & sync2_q;
    fall  = toggle & ~sync2_q;
    cnt_d = toggle ? '0 : ((cnt_q == SAT_T) ? cnt_q : cnt_q + CW'(1));
  end

  always_comb begin
    state_d      = state_q;
    sym_bits_d   = sym_bits_q;
    sym_len_d    = sym_len_q;
    ovf_d        = ovf_q;
    stuck_d      = stuck_q;
    emitted_d    = emitted_q;
    char_valid_d = 1'b0;
    char_ascii_d = char_ascii_q;
    char_err_d   = 1'b0;
    elem         = (cnt_q >= DAH_T) ? DAH : DIT;
    bad          = ovf_q | stuck_q | ~lut_hit;
    emit_char    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d    = MARK;
          sym_bits_d = '0;
          sym_len_d  = '0;
          ovf_d      = 1'b0;
          stuck_d    = 1'b0;
          emitted_d  = 1'b0;
        end
      end
      MARK: begin
        if (fall) begin
          if (sym_len_q == LEN_MAX) begin
            ovf_d = 1'b1;
          end else begin
            sym_bits_d = {sym_bits_q[MAX_ELEMS-2:0], elem};
            sym_len_d  = sym_len_q + 3'd1;
          end
          if (cnt_q == SAT_T) stuck_d = 1'b1;
          state_d = SPACE;
        end
      end
      SPACE: begin
        emit_char = ~emitted_q & (cnt_q == CHAR_T);
        if (emit_char) begin
          char_valid_d = 1'b1;
          char_ascii_d = bad ? ERR_CHAR : lut_ascii;
          char_err_d   = bad;
          emitted_d    = 1'b1;
        end
        if (rise) begin
          state_d = MARK;
          // A mark after the character gap starts a fresh character.
          if (emitted_q | emit_char) begin
            sym_bits_d = '0;
            sym_len_d  = '0;
            ovf_d      = 1'b0;
            stuck_d    = 1'b0;
            emitted_d  = 1'b0;
          end
        end else if (cnt_q == WORD_T) begin
          char_valid_d = 1'b1;
          char_ascii_d = SPACE_CHAR;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      lvl_q        <= 1'b0;
      flt_cnt_q    <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      sym_bits_q   <= '0;
      sym_len_q    <= '0;
      ovf_q        <= 1'b0;
      stuck_q      <= 1'b0;
      emitted_q    <= 1'b0;
      char_valid_q <= 1'b0;
      char_ascii_q <= '0;
      char_err_q   <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      lvl_q        <= lvl_d;
      flt_cnt_q    <= flt_cnt_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      sym_bits_q   <= sym_bits_d;
      sym_len_q    <= sym_len_d;
      ovf_q        <= ovf_d;
      stuck_q      <= stuck_d;
      emitted_q    <= emitted_d;
      char_valid_q <= char_valid_d;
      char_ascii_q <= char_ascii_d;
      char_err_q   <= char_err_d;
    end
  end

  assign char_valid = char_valid_q;
  assign char_ascii = char_ascii_q;
  assign char_err   = char_err_q;
  assign busy       = (state_q != IDLE);

endmodule
